wb_scoreboard: RTL and testbench

//   Producer side of operand forwarding. Tracks registers with results still in flight from

---
 rtl/wb_scoreboard_pkg.sv | 27 ++
 rtl/wb_scoreboard_wb_slot.sv | 34 +++
 rtl/wb_scoreboard.sv | 102 ++++++++++
 tb/tb_wb_scoreboard.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_scoreboard_pkg.sv
// Shared constants for the scoreboard and the forwarding units that read its writeback slot.
// Register index width, the zero register and the default data width live here.
package wb_scoreboard_pkg;

    localparam int REG_W            = 5;
    localparam int NREG_DEF         = 1 << REG_W;
    localparam int DATA_W_DEF       = 32;
    localparam int MAX_INFLIGHT_DEF = 4;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_W-1:0] reg_idx_t;

    // A hazard on r is cancelled when the result for r arrives in this same cycle,
    // because the consumer will read it from the writeback slot one cycle later.
    function automatic logic reg_hazard(
        input logic [NREG_DEF-1:0] pend,
        input reg_idx_t            r,
        input logic                res_valid,
        input reg_idx_t            res_rd
    );
        logic bypass;
        bypass = res_valid && (res_rd == r) && (r != REG_ZERO);
        return pend[r] && !bypass;
    endfunction

endpackage

// File: rtl/wb_scoreboard_wb_slot.sv
// Writeback register stage: captures one completing result per cycle for the register
// file and the operand forwarding muxes; reads as all-zero when no result completed.
module wb_slot
    import wb_scoreboard_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              res_valid,
    input  logic [REG_W-1:0]  res_rd,
    input  logic [DATA_W-1:0] res_data,
    output logic [REG_W-1:0]  wreg_b,
    output logic [DATA_W-1:0] w_data_b,
    output logic              we_b
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wreg_b   <= REG_ZERO;
            w_data_b <= '0;
            we_b     <= 1'b0;
        end else if (res_valid && (res_rd != REG_ZERO)) begin
            wreg_b   <= res_rd;
            w_data_b <= res_data;
            we_b     <= 1'b1;
        end else begin
            wreg_b   <= REG_ZERO;
            w_data_b <= '0;
            we_b     <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_scoreboard.sv
// Issue-side scoreboard: tracks registers awaiting multi-cycle results, stalls issue on
// RAW/WAW hazards or a full in-flight budget, and registers completing results into wb_slot.
module wb_scoreboard
    import wb_scoreboard_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int NREG         = NREG_DEF,
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [REG_W-1:0]  issue_rs,
    input  logic [REG_W-1:0]  issue_rt,
    input  logic [REG_W-1:0]  issue_rd,
    input  logic              issue_mc,
    input  logic              res_valid,
    input  logic [REG_W-1:0]  res_rd,
    input  logic [DATA_W-1:0] res_data,
    output logic              stall,
    output logic [REG_W-1:0]  wreg_b,
    output logic [DATA_W-1:0] w_data_b,
    output logic              we_b,
    output logic [CNT_W-1:0]  inflight,
    output logic              err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;

    logic hz_rs;
    logic hz_rt;
    logic hz_rd;
    logic res_hits;
    logic mc_req;
    logic full;
    logic acc;
    logic alloc;
    logic stray;

    assign hz_rs = reg_hazard(pending, issue_rs, res_valid, res_rd);
    assign hz_rt = reg_hazard(pending, issue_rt, res_valid, res_rd);
    assign hz_rd = reg_hazard(pending, issue_rd, res_valid, res_rd);

    // A result retiring a pending register frees a slot this cycle, so it lifts the full stall.
    assign res_hits = res_valid && pending[res_rd];
    assign mc_req   = issue_mc && (issue_rd != REG_ZERO);
    assign full     = mc_req && (inflight == MAX_CNT) && !res_hits;

    assign stall = issue_valid && (hz_rs || hz_rt || hz_rd || full);
    assign acc   = issue_valid && !stall;
    assign alloc = acc && mc_req;
    assign stray = res_valid && !pending[res_rd];

    // Clear before set: a new producer for the same register keeps it pending.
    always_comb begin
        pending_nxt = pending;
        if (res_valid) begin
            pending_nxt[res_rd] = 1'b0;
        end
        if (alloc) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending  <= '0;
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            pending <= pending_nxt;
            case ({alloc, res_hits})
                2'b10:   inflight <= inflight + CNT_ONE;
                2'b01:   inflight <= inflight - CNT_ONE;
                default: inflight <= inflight;
            endcase
            if (stray) begin
                err <= 1'b1;
            end
        end
    end

    wb_slot #(
        .DATA_W (DATA_W)
    ) u_wb_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .res_valid(res_valid),
        .res_rd   (res_rd),
        .res_data (res_data),
        .wreg_b   (wreg_b),
        .w_data_b (w_data_b),
        .we_b     (we_b)
    );

endmodule

// File: tb/tb_wb_scoreboard.sv
// Bench for wb_scoreboard: directed scenarios with literal expectations, then random traffic
// compared every cycle against a set-of-pending-registers model.
module tb_wb_scoreboard;

    localparam int DATA_W = 32;
    localparam int NREG   = 32;
    localparam int MAXI   = 4;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              issue_valid;
    logic [4:0]        issue_rs;
    logic [4:0]        issue_rt;
    logic [4:0]        issue_rd;
    logic              issue_mc;
    logic              res_valid;
    logic [4:0]        res_rd;
    logic [DATA_W-1:0] res_data;
    logic              stall;
    logic [4:0]        wreg_b;
    logic [DATA_W-1:0] w_data_b;
    logic              we_b;
    logic [CNT_W-1:0]  inflight;
    logic              err;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    wb_scoreboard dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_valid(issue_valid),
        .issue_rs   (issue_rs),
        .issue_rt   (issue_rt),
        .issue_rd   (issue_rd),
        .issue_mc   (issue_mc),
        .res_valid  (res_valid),
        .res_rd     (res_rd),
        .res_data   (res_data),
        .stall      (stall),
        .wreg_b     (wreg_b),
        .w_data_b   (w_data_b),
        .we_b       (we_b),
        .inflight   (inflight),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Model: the set of registers awaiting a result; in-flight count is simply its size.
    bit          m_pend [NREG];
    bit          m_err;
    bit          m_we;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    function automatic bit m_waiting(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (res_valid && res_rd == r) return 1'b0;
        return m_pend[r];
    endfunction

    function automatic bit m_stall();
        bit full;
        if (!issue_valid) return 1'b0;
        full = issue_mc && issue_rd != 5'd0 && m_count() == MAXI
               && !(res_valid && m_pend[res_rd]);
        return m_waiting(issue_rs) || m_waiting(issue_rt) || m_waiting(issue_rd) || full;
    endfunction

    always @(posedge clk) begin
        bit accepted;
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
            m_err = 1'b0; m_we = 1'b0; m_wreg = '0; m_wdata = '0;
        end else begin
            accepted = issue_valid && !m_stall();
            if (res_valid && !m_pend[res_rd]) m_err = 1'b1;
            if (res_valid) m_pend[res_rd] = 1'b0;
            if (accepted && issue_mc && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
            m_we    = res_valid && res_rd != 5'd0;
            m_wreg  = m_we ? res_rd : 5'd0;
            m_wdata = m_we ? res_data : 32'd0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall",    64'(stall),    64'(m_stall()));
            chk("we_b",     64'(we_b),     64'(m_we));
            chk("wreg_b",   64'(wreg_b),   64'(m_wreg));
            chk("w_data_b", 64'(w_data_b), 64'(m_wdata));
            chk("inflight", 64'(inflight), 64'(m_count()));
            chk("err",      64'(err),      64'(m_err));
        end
    end

    task automatic drive(input bit rn, input bit iv, input int rs, input int rt, input int rd,
                         input bit mc, input bit rv, input int rr, input logic [31:0] d);
        @(posedge clk);
        #1;
        rst_n = rn; issue_valid = iv;
        issue_rs = 5'(rs); issue_rt = 5'(rt); issue_rd = 5'(rd); issue_mc = mc;
        res_valid = rv; res_rd = 5'(rr); res_data = d;
        #2;
    endtask

    task automatic idle();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; issue_valid = 1'b0; issue_rs = '0; issue_rt = '0; issue_rd = '0;
        issue_mc = 1'b0; res_valid = 1'b0; res_rd = '0; res_data = '0;

        // reset held two cycles with a result on the bus
        drive(0, 0, 0, 0, 0, 0, 1, 3, 32'h1234_5678);
        drive(0, 0, 0, 0, 0, 0, 1, 3, 32'h1234_5678);
        chk_en = 1'b1;
        idle();
        chk("rst we_b", 64'(we_b), 64'd0);
        chk("rst wreg_b", 64'(wreg_b), 64'd0);
        chk("rst w_data_b", 64'(w_data_b), 64'd0);
        chk("rst inflight", 64'(inflight), 64'd0);
        chk("rst err", 64'(err), 64'd0);
        chk("rst stall", 64'(stall), 64'd0);

        // RAW stall resolved by same-cycle result
        drive(1, 1, 1, 2, 5, 1, 0, 0, 32'd0);
        chk("raw first issue", 64'(stall), 64'd0);
        drive(1, 1, 5, 0, 10, 0, 0, 0, 32'd0);
        chk("raw stall", 64'(stall), 64'd1);
        chk("raw inflight", 64'(inflight), 64'd1);
        drive(1, 1, 5, 0, 10, 0, 0, 0, 32'd0);
        chk("raw stall hold", 64'(stall), 64'd1);
        drive(1, 1, 5, 0, 10, 0, 1, 5, 32'hDEAD_BEEF);
        chk("raw bypass", 64'(stall), 64'd0);
        idle();
        chk("raw wreg_b", 64'(wreg_b), 64'd5);
        chk("raw w_data_b", 64'(w_data_b), 64'hDEAD_BEEF);
        chk("raw we_b", 64'(we_b), 64'd1);
        chk("raw drained", 64'(inflight), 64'd0);

        // full budget; a retiring result lets the fifth issue through
        for (int r = 1; r <= 4; r++) drive(1, 1, 0, 0, r, 1, 0, 0, 32'd0);
        drive(1, 1, 0, 0, 6, 1, 0, 0, 32'd0);
        chk("full stall", 64'(stall), 64'd1);
        chk("full inflight", 64'(inflight), 64'd4);
        drive(1, 1, 0, 0, 6, 1, 1, 1, 32'h0000_0011);
        chk("full release", 64'(stall), 64'd0);
        idle();
        chk("full net zero", 64'(inflight), 64'd4);
        drive(1, 0, 0, 0, 0, 0, 1, 2, 32'h22);
        drive(1, 0, 0, 0, 0, 0, 1, 3, 32'h33);
        drive(1, 0, 0, 0, 0, 0, 1, 4, 32'h44);
        drive(1, 0, 0, 0, 0, 0, 1, 6, 32'h66);
        idle();
        chk("full drained", 64'(inflight), 64'd0);
        chk("no stray err", 64'(err), 64'd0);

        // same-index retire and reissue
        drive(1, 1, 0, 0, 7, 1, 0, 0, 32'd0);
        drive(1, 1, 0, 0, 7, 1, 1, 7, 32'h77);
        chk("reissue accepted", 64'(stall), 64'd0);
        drive(1, 1, 7, 0, 8, 0, 0, 0, 32'd0);
        chk("reissue pending", 64'(stall), 64'd1);
        chk("reissue inflight", 64'(inflight), 64'd1);
        drive(1, 0, 0, 0, 0, 0, 1, 7, 32'h78);
        idle();
        chk("reissue drained", 64'(inflight), 64'd0);

        // stray results
        drive(1, 0, 0, 0, 0, 0, 1, 9, 32'h99);
        idle();
        chk("stray err", 64'(err), 64'd1);
        chk("stray we_b", 64'(we_b), 64'd1);
        chk("stray wreg_b", 64'(wreg_b), 64'd9);
        drive(1, 0, 0, 0, 0, 0, 1, 0, 32'hAA);
        idle();
        chk("r0 stray err", 64'(err), 64'd1);
        chk("r0 stray we_b", 64'(we_b), 64'd0);

        // register zero never tracked
        drive(1, 1, 0, 0, 0, 1, 0, 0, 32'd0);
        chk("r0 issue", 64'(stall), 64'd0);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 32'd0);
        chk("r0 not pending", 64'(stall), 64'd0);
        chk("r0 inflight", 64'(inflight), 64'd0);

        // random traffic, reset first so err starts clear
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'd0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int rr;
            bit rv;
            rv = ($urandom_range(0, 9) < 4);
            rr = int'($urandom_range(0, 7));
            if (rv && $urandom_range(0, 9) != 0) begin
                for (int k = 0; k < 8; k++) begin
                    int c = int'($urandom_range(1, NREG - 1));
                    if (m_pend[c]) begin
                        rr = c;
                        break;
                    end
                end
            end
            drive($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 9)), $urandom_range(0, 1) == 1,
                  rv, rr, $urandom);
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
